// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - handshaked, latency-aware issue controller for a clocked ALU
// Optional build macro ALU_SCOREBOARD_EN adds a reference model and a sticky o_mismatch flag.
module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  input  logic [2:0]       i_req_op,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_op,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_zero,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_zero,
  output logic [2:0]       o_rsp_op,
  output logic [CNT_W-1:0] o_ops_done,
  output logic             o_mismatch
);

  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LAT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [2:0]         r_alu_op;
  logic [WIDTH-1:0]   r_rsp_result;
  logic               r_rsp_zero;
  logic [2:0]         r_rsp_op;
  logic [CNT_W-1:0]   r_ops_done;
  logic               w_accept;
  logic               w_capture;
  logic               w_rsp_fire;

  assign w_accept   = i_req_valid && o_req_ready;
  assign w_capture  = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_rsp_fire = o_rsp_valid && i_rsp_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_next = S_WAIT;
      S_WAIT:  if (w_capture)  w_next = S_RESP;
      S_RESP:  if (w_rsp_fire) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (r_state)
      S_IDLE:  o_req_ready = 1'b1;
      S_RESP:  o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands change only at acceptance so the ALU sees them stable until the next request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_cnt        <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_op     <= '0;
      r_ops_done   <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a  <= i_req_a;
        r_alu_b  <= i_req_b;
        r_alu_op <= i_req_op;
        r_cnt    <= LAT_W'(ALU_LAT);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        r_rsp_result <= i_alu_result;
        r_rsp_zero   <= i_alu_zero;
        r_rsp_op     <= r_alu_op;
      end
      if (w_rsp_fire) r_ops_done <= r_ops_done + CNT_W'(1);
    end
  end

`ifdef ALU_SCOREBOARD_EN
  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] w_exp;
  logic [SH_W-1:0]  w_shamt;
  logic             r_mismatch;

  assign w_shamt = r_alu_b[SH_W-1:0];

  always_comb begin
    w_exp = '0;
    case (r_alu_op)
      3'b000: w_exp = r_alu_a + r_alu_b;
      3'b001: w_exp = r_alu_a - r_alu_b;
      3'b010: w_exp = r_alu_a << w_shamt;
      3'b011: w_exp = r_alu_a >> w_shamt;
      3'b100: w_exp = WIDTH'($signed(r_alu_a) >>> w_shamt);
      3'b101: w_exp = r_alu_a & r_alu_b;
      3'b110: w_exp = r_alu_a | r_alu_b;
      default: w_exp = r_alu_a ^ r_alu_b;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_mismatch <= 1'b0;
    else if (w_capture && ((i_alu_result != w_exp) || (i_alu_zero != (w_exp == '0))))
      r_mismatch <= 1'b1;
  end

  assign o_mismatch = r_mismatch;
`else
  assign o_mismatch = 1'b0;
`endif

  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_op     = r_alu_op;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_zero   = r_rsp_zero;
  assign o_rsp_op     = r_rsp_op;
  assign o_ops_done   = r_ops_done;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
// Small CNT_W so the completed-operation counter wraps within the directed sequence.
module tb_alu_issue_ctrl;
  localparam int WIDTH = 32;
  localparam int LAT   = 1;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic [2:0]       req_op = '0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result = '0;
  logic             alu_zero = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic [2:0]       rsp_op;
  logic [CW-1:0]    ops_done;
  logic             mismatch;
  logic             corrupt = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int n_ops = 0;

  alu_issue_ctrl #(.WIDTH(WIDTH), .ALU_LAT(LAT), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_zero(rsp_zero), .o_rsp_op(rsp_op),
    .o_ops_done(ops_done), .o_mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // One-cycle-latency ALU; 'corrupt' zeroes the add result to provoke the scoreboard.
  always @(posedge clk) begin
    logic [WIDTH-1:0] r;
    case (alu_op)
      3'b000: r = alu_a + alu_b;
      3'b001: r = alu_a - alu_b;
      3'b010: r = alu_a << alu_b[4:0];
      3'b011: r = alu_a >> alu_b[4:0];
      3'b100: r = $signed(alu_a) >>> alu_b[4:0];
      3'b101: r = alu_a & alu_b;
      3'b110: r = alu_a | alu_b;
      default: r = alu_a ^ alu_b;
    endcase
    if (corrupt && alu_op == 3'b000) r = '0;
    alu_result <= r;
    alu_zero   <= (r == '0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp_res,
                        input logic exp_zero, input int stall);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_req_ready_busy"}, 64'(req_ready), 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'(a));
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd2);
    repeat (stall) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_hold_result"}, 64'(rsp_result), 64'(exp_res));
      chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
    end
    chk({tag, "_result"}, 64'(rsp_result), 64'(exp_res));
    chk({tag, "_zero"}, 64'(rsp_zero), 64'(exp_zero));
    chk({tag, "_op"}, 64'(rsp_op), 64'(op));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_ops++;
    chk({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_req_ready_back"}, 64'(req_ready), 64'd1);
    chk({tag, "_ops_done"}, 64'(ops_done), 64'(n_ops % 8));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(alu_b), 64'd0);
    chk({tag, "_alu_op"}, 64'(alu_op), 64'd0);
    chk({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    chk({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
    chk({tag, "_rsp_op"}, 64'(rsp_op), 64'd0);
    chk({tag, "_ops_done"}, 64'(ops_done), 64'd0);
    chk({tag, "_mismatch"}, 64'(mismatch), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add", 32'h12345678, 32'h87654321, 3'b000, 32'h99999999, 1'b0, 0);
    run_op("sub", 32'h12345678, 32'h12345678, 3'b001, 32'h00000000, 1'b1, 0);
    run_op("sll", 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'hFFFFFFFE, 1'b0, 0);
    run_op("srl", 32'hFFFFFFFF, 32'h00000001, 3'b011, 32'h7FFFFFFF, 1'b0, 0);
    run_op("sra", 32'hFFFFFFFF, 32'h00000001, 3'b100, 32'hFFFFFFFF, 1'b0, 0);
    run_op("and", 32'h0000FFFF, 32'h00FFFF00, 3'b101, 32'h0000FF00, 1'b0, 5);
    run_op("or",  32'h0000FFFF, 32'h00FFFF00, 3'b110, 32'h00FFFFFF, 1'b0, 0);
    run_op("xor", 32'h0000FFFF, 32'h00FFFF00, 3'b111, 32'h00FF00FF, 1'b0, 0);
    chk("no_mismatch", 64'(mismatch), 64'd0);

    // Abort during WAIT: no response must appear.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'h00000005; req_b = 32'h00000003; req_op = 3'b000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_wait", 64'(req_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_reset_state("abort_rst");
    @(negedge clk);
    rst_n = 1'b1;
    n_ops = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    chk_reset_state("abort_post");

`ifdef ALU_SCOREBOARD_EN
    corrupt = 1'b1;
    run_op("bad_add", 32'h12345678, 32'h87654321, 3'b000, 32'h00000000, 1'b1, 0);
    corrupt = 1'b0;
    chk("sb_set", 64'(mismatch), 64'd1);
    run_op("good_xor", 32'h0000FFFF, 32'h00FFFF00, 3'b111, 32'h00FF00FF, 1'b0, 0);
    chk("sb_sticky", 64'(mismatch), 64'd1);
`else
    run_op("post_add", 32'h12345678, 32'h87654321, 3'b000, 32'h99999999, 1'b0, 0);
    chk("sb_off", 64'(mismatch), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
